// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: ROM placement, fetch-buffer entry layout
// and the address-error check used when FETCH_EXC_EN is defined.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int unsigned ROM_WORDS = 4096;
    localparam logic [31:0] ROM_LIMIT = RESET_PC + 32'(ROM_WORDS * 4);
    localparam logic [1:0]  BUF_DEPTH = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // Misaligned or outside the ROM window [RESET_PC, ROM_LIMIT)
    function automatic logic fetch_addr_exc(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc >= ROM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, instr, exc} records; flush empties it.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    fetch_entry_t head_s;

    // Storage, pointers and occupancy; push and pop may coincide when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head entry, zeroed while the buffer is empty
    always_comb begin
        head_s = '0;
        if (count_r != 2'd0) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign head  = head_s;
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one ROM word per cycle into fetch_buf and
// hands {pc, instr} to decode. Optional address-error trapping under macro FETCH_EXC_EN.
module fetch_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc
);

    logic [31:0]  pc_r;
    fetch_state_t state_r;
    fetch_entry_t entry_s;
    fetch_entry_t head_s;
    logic [1:0]   count_s;
    logic         deq_s;
    logic         fetch_s;
    logic         exc_s;

`ifdef FETCH_EXC_EN
    assign exc_s = fetch_addr_exc(pc_r);
`else
    assign exc_s = 1'b0;
`endif

    // A redirect cancels both the dequeue and the fetch of its cycle
    assign deq_s   = (count_s != 2'd0) && if_ready && !redirect_valid;
    assign fetch_s = (state_r == ST_RUN) && !redirect_valid &&
                     ((count_s < BUF_DEPTH) || deq_s);

    // Build the record to enqueue; excepting fetches carry a zero instruction
    always_comb begin
        entry_s.pc  = pc_r;
        entry_s.exc = exc_s;
        if (exc_s) begin
            entry_s.instr = 32'h0000_0000;
        end else begin
            entry_s.instr = imem_instr;
        end
    end

    // PC and RUN/HALT state; HALT is left only through a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            state_r <= ST_RUN;
        end else if (redirect_valid) begin
            pc_r    <= redirect_pc;
            state_r <= ST_RUN;
        end else if (fetch_s) begin
            pc_r <= pc_r + 32'd4;
            if (exc_s) begin
                state_r <= ST_HALT;
            end
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fetch_s),
        .pop        (deq_s),
        .push_entry (entry_s),
        .head       (head_s),
        .count      (count_s)
    );

    assign imem_pc  = pc_r;
    assign if_valid = (count_s != 2'd0);
    assign if_pc    = head_s.pc;
    assign if_instr = head_s.instr;
    assign if_exc   = head_s.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural ROM; build with
// +define+FETCH_EXC_EN to include the address-error sequences.
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        eexc;
        logic [31:0] empc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc;

    logic [31:0] rom [4096];
    logic [11:0] rom_idx;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl [$];

    always #5 clk = ~clk;

    assign rom_idx    = 12'((imem_pc - 32'h0000_3000) >> 2);
    assign imem_instr = rom[rom_idx];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_exc         (if_exc)
    );

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic eexc, input logic [31:0] empc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
        v.epc = epc; v.einstr = einstr; v.eexc = eexc; v.empc = empc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", n_vec, nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge
    task automatic apply(input vec_t v);
        rst_n          = !v.rst;
        if_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        #1;
        chk("if_valid", {31'd0, if_valid}, {31'd0, v.ev});
        chk("if_pc",    if_pc,    v.epc);
        chk("if_instr", if_instr, v.einstr);
        chk("if_exc",   {31'd0, if_exc}, {31'd0, v.eexc});
        chk("imem_pc",  imem_pc,  v.empc);
        n_vec++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 32'hC0DE_0000 + 32'(i);
        end
        rom[0] = 32'h0000_0011;
        rom[1] = 32'h0000_0022;
        rom[2] = 32'h0000_0033;
        rom[3] = 32'h0000_0044;

        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        @(posedge clk);
        #1;

        // rst rdy rv rpc | valid pc instr exc imem_pc
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3004));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3004, 32'h0000_0022, 1'b0, 32'h0000_3008));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3008, 32'h0000_0033, 1'b0, 32'h0000_300C));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_300C, 32'h0000_0044, 1'b0, 32'h0000_3010));
        // stall with if_ready low: buffer fills, PC holds at 0x3008
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3004));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3008));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3008));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3008));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3008));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3004, 32'h0000_0022, 1'b0, 32'h0000_300C));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3008, 32'h0000_0033, 1'b0, 32'h0000_3010));
        // redirect from a full buffer to 0x3040
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0000_3040, 1'b1, 32'h0000_3008, 32'h0000_0033, 1'b0, 32'h0000_3010));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3040));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3040, 32'hC0DE_0010, 1'b0, 32'h0000_3044));
        // redirect together with if_ready: head is dropped, not consumed
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0000_3080, 1'b1, 32'h0000_3044, 32'hC0DE_0011, 1'b0, 32'h0000_3048));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3080));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3080, 32'hC0DE_0020, 1'b0, 32'h0000_3084));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3080, 32'hC0DE_0020, 1'b0, 32'h0000_3088));
        // reset with two entries buffered
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3004));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

`ifdef FETCH_EXC_EN
        // misaligned target: one excepting entry, then silence until redirected
        apply(mk(1'b0, 1'b1, 1'b1, 32'h0000_3002, 1'b1, 32'h0000_3004, 32'h0000_0022, 1'b0, 32'h0000_3008));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3002));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3002, 32'h0,         1'b1, 32'h0000_3006));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3006));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3006));
        apply(mk(1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0,         1'b0, 32'h0000_3006));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3004));
        // out-of-range target 0x7000 (first address past the ROM)
        apply(mk(1'b0, 1'b1, 1'b1, 32'h0000_7000, 1'b1, 32'h0000_3004, 32'h0000_0022, 1'b0, 32'h0000_3008));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_7000));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_7000, 32'h0,         1'b1, 32'h0000_7004));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_7004));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_7004));
        apply(mk(1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0,         1'b0, 32'h0000_7004));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3000));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_0011, 1'b0, 32'h0000_3004));
`else
        // PC wraps modulo 2^32 and out-of-range addresses alias into the ROM
        apply(mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_3004, 32'h0000_0022, 1'b0, 32'h0000_3008));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFC));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hC0DE_03FF, 1'b0, 32'h0000_0000));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'hC0DE_0400, 1'b0, 32'h0000_0004));
        // misaligned target is fetched without trapping
        apply(mk(1'b0, 1'b1, 1'b1, 32'h0000_3002, 1'b1, 32'h0000_0004, 32'hC0DE_0401, 1'b0, 32'h0000_0008));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_3002));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3002, 32'h0000_0011, 1'b0, 32'h0000_3006));
        apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3006, 32'h0000_0022, 1'b0, 32'h0000_300A));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
